data_sram_bridge: RTL

Responder end of the CPU data-SRAM interface. The EX stage drives this interface, and the MEM stage samples the read data one cycle after the request. The block accepts en/wen/addr/wdata requests and forwards them to a multi-cycle backing memory over a req/ready + rvalid handshake. It presents read data to the MEM stage and raises a stall request while a transaction is outstanding, so the pipeline freezes until the data is valid.

---
 rtl/data_sram_bridge_pkg.sv | 16 +
 rtl/data_sram_bridge_watchdog.sv | 16 +
 rtl/data_sram_bridge.sv | 73 +++++++
 3 files changed

// File: rtl/data_sram_bridge_pkg.sv
// data_sram_bridge_pkg: shared state encoding, bus widths and helpers for the data-SRAM bridge
package data_sram_bridge_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    RWAIT = 2'd2,
    DONE  = 2'd3
  } state_t;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int STRB_W = 4;
  localparam logic [DATA_W-1:0] ERR_DATA_DEFAULT = 32'hDEADBEEF;
  function automatic logic [ADDR_W-1:0] word_addr(input logic [ADDR_W-1:0] a);
    return a & ~32'h3;
  endfunction
endpackage

// File: rtl/data_sram_bridge_watchdog.sv
// mem_watchdog: busy-cycle counter that expires on the cycle its count would reach TIMEOUT
module mem_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);
  logic [31:0] cnt;
  always_ff @(posedge clk)
    cnt <= (rst || clr) ? 32'd0 : en ? cnt + 32'd1 : cnt;
  always_comb
    expire = (TIMEOUT != 0) && en && (cnt == 32'(TIMEOUT - 1));
endmodule

// File: rtl/data_sram_bridge.sv
// data_sram_bridge: CPU data-SRAM responder forwarding requests to a multi-cycle backing memory
module data_sram_bridge
  import data_sram_bridge_pkg::*;
#(
  parameter int          TIMEOUT  = 255,
  parameter logic [31:0] ERR_DATA = ERR_DATA_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        stallreq_for_mem,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_wstrb,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_ready,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        timeout_err
);
  state_t state, state_nxt;
  logic accept, cap, fin, expire, tmo;
  mem_watchdog #(.TIMEOUT(TIMEOUT)) u_wdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (accept),
    .en     (stallreq_for_mem),
    .expire (expire)
  );
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_nxt;
  always_comb
    state_nxt = accept ? REQ :
                (state == IDLE || state == DONE) ? IDLE :
                (fin || tmo) ? DONE :
                (state == REQ && mem_ready) ? RWAIT : state;
  always_comb begin
    stallreq_for_mem = (state == REQ) || (state == RWAIT);
    mem_req          = state == REQ;
    accept           = !stallreq_for_mem && data_sram_en;
    cap              = !mem_we && mem_rvalid && ((state == REQ && mem_ready) || state == RWAIT);
    fin              = cap || (state == REQ && mem_ready && mem_we);
    tmo              = expire && !fin;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_we          <= 1'b0;
      mem_wstrb       <= 4'd0;
      mem_addr        <= 32'd0;
      mem_wdata       <= 32'd0;
      data_sram_rdata <= 32'd0;
      timeout_err     <= 1'b0;
    end else begin
      if (accept) begin
        mem_we    <= |data_sram_wen;
        mem_wstrb <= data_sram_wen;
        mem_addr  <= word_addr(data_sram_addr);
        mem_wdata <= data_sram_wdata;
      end
      if (cap)
        data_sram_rdata <= mem_rdata;
      else if (tmo && !mem_we)
        data_sram_rdata <= ERR_DATA;
      if (tmo)
        timeout_err <= 1'b1;
    end
  end
endmodule
